// File: rtl/fader_pkg.sv
// Shared constants, state encoding and helpers for the fader frame sequencer.
package fader_pkg;

    localparam int N_CHAN     = 32;
    localparam int M_REFL     = 8;
    localparam int T_WIDTH    = 25;
    localparam int FRAME_LEN  = N_CHAN * M_REFL;
    localparam int STAT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        RUN,
        DONE
    } sched_state_t;

    // Saturating increment used by the statistics counters.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/fader_scheduler_if.sv
// Start/result handshake between the frame scheduler (master) and the fader core (slave).
interface fader_scheduler_if;
    import fader_pkg::*;

    logic               start;
    logic [T_WIDTH-1:0] t_index;
    logic               dv;

    modport master (output start, output t_index, input dv);
    modport slave  (input start, input t_index, output dv);
endinterface

// File: rtl/fader_rate_div.sv
// Programmable sample-rate divider: one tick every rate_div+1 cycles while run is high.
module fader_rate_div #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] rate_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count;

    assign tick = run && (count == rate_div);

    // A shrunken rate_div leaves count above the limit; wrap silently without a tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!run || count >= rate_div) begin
            count <= '0;
        end else begin
            count <= count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fader_scheduler.sv
// Frame sequencer for the sum-of-sinusoids fader: tick -> start -> count results -> done.
// Optional statistics counters are built when FADER_SCHED_STATS_EN is defined.
module fader_scheduler
    import fader_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] rate_div,
    input  logic [T_WIDTH-1:0]   t_step,
    input  logic                 t_load,
    input  logic [T_WIDTH-1:0]   t_load_val,
    input  logic                 overrun_clr,
    fader_scheduler_if.master    fader,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic                 timeout,
    output logic [15:0]          frame_count,
    output logic [15:0]          overrun_count
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    sched_state_t       state, state_nx;
    logic               tick, in_frame, last_dv, expire, ovr_evt;
    logic [CNT_W-1:0]   dv_cnt;
    logic [TMR_W-1:0]   timer;
    logic [T_WIDTH-1:0] t_cur, t_index;

    fader_rate_div #(.DIV_WIDTH(DIV_WIDTH)) u_rate_div (
        .clk      (clk),
        .reset    (reset),
        .run      (state != IDLE),
        .rate_div (rate_div),
        .tick     (tick)
    );

    assign in_frame = (state == START) || (state == RUN) || (state == DONE);
    assign last_dv  = (state == RUN) && fader.dv && (dv_cnt == CNT_W'(FRAME_LEN - 1));
    assign expire   = (state == RUN) && (timer == TMR_W'(TIMEOUT - 1)) && !last_dv;
    assign ovr_evt  = tick && in_frame;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: state_nx gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = ARMED;
            ARMED:   if (!enable) state_nx = IDLE;
                     else if (tick) state_nx = START;
            START:   state_nx = RUN;
            RUN:     if (last_dv || expire) state_nx = DONE;
            DONE:    state_nx = enable ? ARMED : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_cur   <= '0;
            t_index <= '0;
            dv_cnt  <= '0;
            timer   <= '0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE && t_load) t_cur <= t_load_val;
            else if (state == DONE)      t_cur <= t_cur + t_step;

            // Captured on the way into START so the index is valid with the start pulse.
            if (state == ARMED && state_nx == START) t_index <= t_cur;

            if (state == START) begin
                dv_cnt <= '0;
                timer  <= '0;
            end else if (state == RUN) begin
                timer <= timer + TMR_W'(1);
                if (fader.dv) dv_cnt <= dv_cnt + CNT_W'(1);
            end

            if (overrun_clr)  overrun <= 1'b0;
            else if (ovr_evt) overrun <= 1'b1;

            if (overrun_clr) timeout <= 1'b0;
            else if (expire) timeout <= 1'b1;
        end
    end

    assign fader.start   = (state == START);
    assign fader.t_index = t_index;
    assign busy          = in_frame;
    assign frame_done    = (state == DONE);

`ifdef FADER_SCHED_STATS_EN
    logic [15:0] frame_cnt, ovr_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            ovr_cnt   <= '0;
        end else if (overrun_clr) begin
            frame_cnt <= '0;
            ovr_cnt   <= '0;
        end else begin
            if (state == DONE) frame_cnt <= sat_inc(frame_cnt);
            if (ovr_evt)       ovr_cnt   <= sat_inc(ovr_cnt);
        end
    end

    assign frame_count   = frame_cnt;
    assign overrun_count = ovr_cnt;
`else
    assign frame_count   = '0;
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_fader_scheduler.sv
// Self-checking bench for fader_scheduler: directed and randomized frames against a tick-level model.
module tb_fader_scheduler;
    import fader_pkg::*;

    localparam int TIMEOUT = 1024;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic               t_load = 1'b0;
    logic               overrun_clr = 1'b0;
    logic [15:0]        rate_div = '0;
    logic [T_WIDTH-1:0] t_step = '0;
    logic [T_WIDTH-1:0] t_load_val = '0;
    logic               busy, frame_done, overrun, timeout;
    logic [15:0]        frame_count, overrun_count;

    fader_scheduler_if fif ();

    fader_scheduler #(.DIV_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .rate_div      (rate_div),
        .t_step        (t_step),
        .t_load        (t_load),
        .t_load_val    (t_load_val),
        .overrun_clr   (overrun_clr),
        .fader         (fif),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .timeout       (timeout),
        .frame_count   (frame_count),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event monitor: records start cycle/index and frame_done cycles.
    int                 start_q[$];
    logic [T_WIDTH-1:0] idx_q[$];
    int                 done_q[$];
    always @(negedge clk) begin
        if (fif.start) begin
            start_q.push_back(cyc);
            idx_q.push_back(fif.t_index);
        end
        if (frame_done) done_q.push_back(cyc);
    end

    // Fader model: dv_count results, one per cycle, starting dv_delay cycles after start.
    int dv_delay = 3;
    int dv_count = 256;
    int dv_issued = 0;
    initial begin
        fif.dv = 1'b0;
        forever begin
            @(negedge clk);
            if (fif.start) begin
                dv_issued = 0;
                repeat (dv_delay) @(negedge clk);
                for (int k = 0; k < dv_count; k++) begin
                    fif.dv = 1'b1;
                    dv_issued++;
                    @(negedge clk);
                end
                fif.dv = 1'b0;
            end
        end
    end

    // Reference model: ticks fall at a+p-1+k*p; a tick starts a frame only if the
    // scheduler is waiting and enable is still high, otherwise it is an overrun.
    int exp_start[$];
    int exp_done[$];
    int exp_ovr;
    task automatic predict(input int a, input int x, input int p, input int run_len);
        int next_free, t;
        exp_start.delete();
        exp_done.delete();
        exp_ovr   = 0;
        next_free = a;
        t         = a + p - 1;
        while (1) begin
            if (t >= next_free) begin
                if (t >= x) break;
                exp_start.push_back(t + 1);
                exp_done.push_back(t + run_len + 2);
                next_free = t + run_len + 3;
            end else begin
                exp_ovr++;
            end
            t += p;
        end
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({tag, "_idle_wait"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_scn(input string tag, input int rd, input int d, input int n,
                           input logic [T_WIDTH-1:0] step, input logic [T_WIDTH-1:0] load,
                           input int window, input bit stop_at_dv50);
        int a, x, run_len, nmin;
        logic [T_WIDTH-1:0] idx;
        @(negedge clk);
        rate_div    = 16'(rd);
        t_step      = step;
        dv_delay    = d;
        dv_count    = n;
        overrun_clr = 1'b1;
        t_load      = 1'b1;
        t_load_val  = load;
        start_q.delete();
        idx_q.delete();
        done_q.delete();
        @(negedge clk);
        overrun_clr = 1'b0;
        t_load      = 1'b0;
        enable      = 1'b1;
        a = cyc + 1;
        @(negedge clk);
        t_load     = 1'b1;
        t_load_val = T_WIDTH'($urandom);
        if (stop_at_dv50) begin
            for (int i = 0; i < 4000 && start_q.size() < 2; i++) @(posedge clk);
            check({tag, "_start_wait"}, 32'(start_q.size() >= 2), 32'd1);
            for (int i = 0; i < 400 && dv_issued < 50; i++) @(posedge clk);
            check({tag, "_dv50_wait"}, 32'(dv_issued >= 50), 32'd1);
        end else begin
            repeat (window) @(negedge clk);
        end
        @(negedge clk);
        enable = 1'b0;
        t_load = 1'b0;
        x = cyc;
        wait_idle(tag);

        run_len = (n >= FRAME_LEN) ? d + FRAME_LEN - 1 : TIMEOUT;
        predict(a, x, rd + 1, run_len);

        check({tag, "_nstart"}, 32'(start_q.size()), 32'(exp_start.size()));
        check({tag, "_ndone"}, 32'(done_q.size()), 32'(exp_done.size()));
        nmin = (start_q.size() < exp_start.size()) ? start_q.size() : exp_start.size();
        idx  = load;
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("%s_start%0d_cyc", tag, i), 32'(start_q[i]), 32'(exp_start[i]));
            check($sformatf("%s_start%0d_idx", tag, i), 32'(idx_q[i]), 32'(idx));
            if (i < done_q.size())
                check($sformatf("%s_done%0d_cyc", tag, i), 32'(done_q[i]), 32'(exp_done[i]));
            if (i < nmin - 1) idx = idx + step;
        end
        if (exp_start.size() > 0)
            check({tag, "_idx_held"}, 32'(fif.t_index), 32'(idx));
        check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr > 0));
        check({tag, "_timeout"}, 32'(timeout), 32'(n < FRAME_LEN && exp_start.size() > 0));
`ifdef FADER_SCHED_STATS_EN
        check({tag, "_frame_count"}, 32'(frame_count), 32'(exp_start.size()));
        check({tag, "_overrun_count"}, 32'(overrun_count), 32'(exp_ovr));
`else
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        check({tag, "_overrun_count"}, 32'(overrun_count), 32'd0);
`endif
        if (stop_at_dv50) begin
            repeat (700) @(negedge clk);
            check({tag, "_no_restart"}, 32'(start_q.size()), 32'(exp_start.size()));
            check({tag, "_busy_after"}, 32'(busy), 32'd0);
        end

        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check({tag, "_clr_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_clr_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_clr_counts"}, {frame_count, overrun_count}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_start", 32'(fif.start), 32'd0);
        check("rst_t_index", 32'(fif.t_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_flags", {30'd0, overrun, timeout}, 32'd0);
        check("rst_counts", {frame_count, overrun_count}, 32'd0);
        reset = 1'b1;

        run_scn("normal", 299, 3, 256, T_WIDTH'(5), T_WIDTH'(0), 3 * 300 + 20, 1'b0);
        run_scn("overrun", 99, 3, 256, T_WIDTH'(7), T_WIDTH'(100), 1000, 1'b0);
        run_scn("timeout", 1099, 2, 100, T_WIDTH'(9), T_WIDTH'(40), 2 * 1100 + 50, 1'b0);
        run_scn("wrap", 299, 1, 256, T_WIDTH'(3), T_WIDTH'(25'h1FFFFFE), 2 * 300 + 20, 1'b0);
        for (int r = 0; r < 3; r++) begin
            run_scn($sformatf("rand%0d", r), int'($urandom_range(40, 700)),
                    int'($urandom_range(1, 4)), 256, T_WIDTH'($urandom), T_WIDTH'($urandom),
                    int'($urandom_range(1200, 2500)), 1'b0);
        end
        run_scn("disable", 299, 3, 256, T_WIDTH'(11), T_WIDTH'(1000), 0, 1'b1);

        // Asynchronous reset in the middle of a frame, with an overrun already flagged.
        @(negedge clk);
        rate_div = 16'd50;
        dv_delay = 2;
        dv_count = 256;
        enable   = 1'b1;
        for (int i = 0; i < 2000 && !(busy && dv_issued >= 120); i++) @(posedge clk);
        check("rstmid_reach_run", 32'(busy && dv_issued >= 120), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_start", 32'(fif.start), 32'd0);
        check("rstmid_t_index", 32'(fif.t_index), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_frame_done", 32'(frame_done), 32'd0);
        check("rstmid_flags", {30'd0, overrun, timeout}, 32'd0);
        check("rstmid_counts", {frame_count, overrun_count}, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start_q.delete();
        repeat (400) @(negedge clk);
        check("rstmid_no_start", 32'(start_q.size()), 32'd0);
        check("rstmid_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
